// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: BCD digit type, digit limits,
// the packed time-of-day record and the set-time validity check.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX        = 4'd5;
  localparam bcd_t MIN_TENS_MAX        = 4'd5;
  localparam bcd_t HOUR_TENS_MAX       = 4'd2;
  localparam bcd_t HOUR_UNITS_MAX_AT_2 = 4'd3;
  localparam bcd_t UNITS_MAX           = 4'd9;

  typedef struct packed {
    bcd_t h1;
    bcd_t h0;
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } time_t;

  // True when hh:mm is a legal 24-hour time; also used by the set-up block.
  function automatic logic set_time_valid(input bcd_t h1, input bcd_t h0,
                                          input bcd_t m1, input bcd_t m0);
    logic h0_ok;
    h0_ok = (h1 == HOUR_TENS_MAX) ? (h0 <= HOUR_UNITS_MAX_AT_2) : (h0 <= UNITS_MAX);
    return (h1 <= HOUR_TENS_MAX) && h0_ok && (m1 <= MIN_TENS_MAX) && (m0 <= UNITS_MAX);
  endfunction

endpackage

// File: rtl/clock_tick_gen.sv
// Seconds prescaler: counts 0..TICK_DIV-1 and flags the terminal-count cycle.
// hold parks the counter at 0 (set mode); clear restarts it from 0 (time load).
module clock_tick_gen #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Prescaler counter with hold/clear and wrap at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hold || clear || (cnt == TERM)) begin
      cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Terminal-count cycle is the tick; hold suppresses it immediately.
  assign tick = !hold && (cnt == TERM);

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day counter with its own 1 Hz prescaler, freeze in
// set mode, and validated hour/minute load from the time-setting block.
module time_keeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_mode,
  input  logic       set_load,
  input  logic [3:0] set_h1,
  input  logic [3:0] set_h0,
  input  logic [3:0] set_m1,
  input  logic [3:0] set_m0,
  output logic [3:0] hour1,
  output logic [3:0] hour0,
  output logic [3:0] minute1,
  output logic [3:0] minute0,
  output logic [3:0] second1,
  output logic [3:0] second0,
  output logic       tick_1hz,
  output logic       hour_chime,
  output logic       day_wrap,
  output logic       load_err
);

  time_t cur;
  time_t nxt;
  logic  tick;
  logic  load_ok;
  logic  load_bad;
  logic  sec_carry;
  logic  min_carry;
  logic  day_carry;

  assign load_ok  = set_load &&  set_time_valid(set_h1, set_h0, set_m1, set_m0);
  assign load_bad = set_load && !set_time_valid(set_h1, set_h0, set_m1, set_m0);

  // A valid load restarts the second so the first tick is a full period away.
  clock_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (set_mode),
    .clear (load_ok),
    .tick  (tick)
  );

  assign sec_carry = (cur.s0 == UNITS_MAX) && (cur.s1 == SEC_TENS_MAX);
  assign min_carry = sec_carry && (cur.m0 == UNITS_MAX) && (cur.m1 == MIN_TENS_MAX);
  assign day_carry = min_carry && (cur.h1 == HOUR_TENS_MAX) && (cur.h0 == HOUR_UNITS_MAX_AT_2);

  // Time one second later, via the BCD carry chain s0 -> s1 -> m0 -> m1 -> hours.
  always_comb begin
    // NOTE: default assignment first so every path assigns nxt and no latch
    // is inferred.
    nxt = cur;
    nxt.s0 = (cur.s0 == UNITS_MAX) ? 4'd0 : cur.s0 + 4'd1;
    if (cur.s0 == UNITS_MAX) begin
      nxt.s1 = (cur.s1 == SEC_TENS_MAX) ? 4'd0 : cur.s1 + 4'd1;
    end
    if (sec_carry) begin
      nxt.m0 = (cur.m0 == UNITS_MAX) ? 4'd0 : cur.m0 + 4'd1;
      if (cur.m0 == UNITS_MAX) begin
        nxt.m1 = (cur.m1 == MIN_TENS_MAX) ? 4'd0 : cur.m1 + 4'd1;
      end
    end
    if (min_carry) begin
      if (day_carry) begin
        nxt.h1 = 4'd0;
        nxt.h0 = 4'd0;
      end else if (cur.h0 == UNITS_MAX) begin
        nxt.h1 = cur.h1 + 4'd1;
        nxt.h0 = 4'd0;
      end else begin
        nxt.h0 = cur.h0 + 4'd1;
      end
    end
  end

  // Time register and event pulses; a valid load overrides a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= '0;
      tick_1hz   <= 1'b0;
      hour_chime <= 1'b0;
      day_wrap   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      tick_1hz   <= 1'b0;
      hour_chime <= 1'b0;
      day_wrap   <= 1'b0;
      load_err   <= load_bad;
      if (load_ok) begin
        cur <= '{h1: set_h1, h0: set_h0, m1: set_m1, m0: set_m0, s1: 4'd0, s0: 4'd0};
      end else if (tick) begin
        cur        <= nxt;
        tick_1hz   <= 1'b1;
        hour_chime <= min_carry;
        day_wrap   <= day_carry;
      end
    end
  end

  assign hour1   = cur.h1;
  assign hour0   = cur.h0;
  assign minute1 = cur.m1;
  assign minute0 = cur.m0;
  assign second1 = cur.s1;
  assign second0 = cur.s0;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV = 4. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_mode = 1'b0;
  logic       set_load = 1'b0;
  logic [3:0] set_h1 = '0;
  logic [3:0] set_h0 = '0;
  logic [3:0] set_m1 = '0;
  logic [3:0] set_m0 = '0;
  logic [3:0] hour1, hour0, minute1, minute0, second1, second0;
  logic       tick_1hz, hour_chime, day_wrap, load_err;

  int vectors = 0;
  int miscompares = 0;

  time_keeper #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_mode   (set_mode),
    .set_load   (set_load),
    .set_h1     (set_h1),
    .set_h0     (set_h0),
    .set_m1     (set_m1),
    .set_m0     (set_m0),
    .hour1      (hour1),
    .hour0      (hour0),
    .minute1    (minute1),
    .minute0    (minute0),
    .second1    (second1),
    .second0    (second0),
    .tick_1hz   (tick_1hz),
    .hour_chime (hour_chime),
    .day_wrap   (day_wrap),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] now_t();
    return {hour1, hour0, minute1, minute0, second1, second0};
  endfunction

  function automatic logic [3:0] pulses();
    return {tick_1hz, hour_chime, day_wrap, load_err};
  endfunction

  // One rising edge, then return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [3:0] h1, input logic [3:0] h0,
                         input logic [3:0] m1, input logic [3:0] m0);
    set_h1 = h1; set_h0 = h0; set_m1 = m1; set_m0 = m0;
    set_load = 1'b1;
    step();
    set_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (now_t() !== 24'h000000) begin
      $display("FAIL reset_time: got %h want 000000", now_t()); miscompares++;
    end
    vectors++;
    if (pulses() !== 4'b0000) begin
      $display("FAIL reset_pulses: got %b want 0000", pulses()); miscompares++;
    end
    rst_n = 1'b1;
    // Tick pulse every 4th edge; ten seconds after 40 cycles.
    for (int k = 1; k <= 40; k++) begin
      step();
      vectors++;
      if (tick_1hz !== (k % 4 == 0)) begin
        $display("FAIL free_run_tick k=%0d: got %b want %b", k, tick_1hz, (k % 4 == 0));
        miscompares++;
      end
    end
    vectors++;
    if (now_t() !== 24'h000010) begin
      $display("FAIL free_run_time: got %h want 000010", now_t()); miscompares++;
    end
  endtask

  task automatic test_rollover(input logic [3:0] h1, input logic [3:0] h0,
                               input logic [3:0] m1, input logic [3:0] m0,
                               input logic [23:0] exp_pre, input logic [23:0] exp_end,
                               input logic exp_day);
    do_load(h1, h0, m1, m0);
    vectors++;
    if (now_t() !== {h1, h0, m1, m0, 8'h00}) begin
      $display("FAIL rollover_load: got %h want %h", now_t(), {h1, h0, m1, m0, 8'h00});
      miscompares++;
    end
    for (int k = 1; k <= 240; k++) begin
      step();
      vectors++;
      if (tick_1hz !== (k % 4 == 0)) begin
        $display("FAIL rollover_tick k=%0d: got %b want %b", k, tick_1hz, (k % 4 == 0));
        miscompares++;
      end
      vectors++;
      if (hour_chime !== (k == 240)) begin
        $display("FAIL hour_chime k=%0d: got %b want %b", k, hour_chime, (k == 240));
        miscompares++;
      end
      vectors++;
      if (day_wrap !== (exp_day && k == 240)) begin
        $display("FAIL day_wrap k=%0d: got %b want %b", k, day_wrap, (exp_day && k == 240));
        miscompares++;
      end
      if (k == 236) begin
        vectors++;
        if (now_t() !== exp_pre) begin
          $display("FAIL rollover_pre: got %h want %h", now_t(), exp_pre); miscompares++;
        end
      end
      if (k == 240) begin
        vectors++;
        if (now_t() !== exp_end) begin
          $display("FAIL rollover_end: got %h want %h", now_t(), exp_end); miscompares++;
        end
      end
    end
  endtask

  task automatic test_bad_load();
    set_mode = 1'b1;
    do_load(4'd1, 4'd2, 4'd0, 4'd0);
    vectors++;
    if (now_t() !== 24'h120000 || load_err !== 1'b0) begin
      $display("FAIL bad_load_setup: got %h err=%b want 120000 err=0", now_t(), load_err);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       do_load(4'd2, 4'd4, 4'd0, 4'd0);
        1:       do_load(4'd1, 4'd9, 4'd6, 4'd0);
        2:       do_load(4'd3, 4'd0, 4'd0, 4'd0);
        default: do_load(4'd0, 4'd9, 4'd5, 4'd10);
      endcase
      vectors++;
      if (load_err !== 1'b1) begin
        $display("FAIL bad_load_err i=%0d: got %b want 1", i, load_err); miscompares++;
      end
      vectors++;
      if (now_t() !== 24'h120000) begin
        $display("FAIL bad_load_time i=%0d: got %h want 120000", i, now_t()); miscompares++;
      end
      step();
      vectors++;
      if (load_err !== 1'b0) begin
        $display("FAIL bad_load_pulse_len i=%0d: got %b want 0", i, load_err); miscompares++;
      end
    end
    set_mode = 1'b0;
  endtask

  task automatic test_load_boundary();
    step();
    do_load(4'd2, 4'd3, 4'd5, 4'd9);
    vectors++;
    if (now_t() !== 24'h235900 || load_err !== 1'b0) begin
      $display("FAIL load_2359: got %h err=%b want 235900 err=0", now_t(), load_err);
      miscompares++;
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (tick_1hz !== (k == 4)) begin
        $display("FAIL first_tick k=%0d: got %b want %b", k, tick_1hz, (k == 4));
        miscompares++;
      end
    end
    vectors++;
    if (now_t() !== 24'h235901) begin
      $display("FAIL first_tick_time: got %h want 235901", now_t()); miscompares++;
    end
  endtask

  task automatic test_coincident();
    do_load(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (224) step();
    vectors++;
    if (now_t() !== 24'h123456) begin
      $display("FAIL coincident_setup: got %h want 123456", now_t()); miscompares++;
    end
    repeat (3) step();
    // Prescaler is at terminal count during this cycle.
    do_load(4'd0, 4'd8, 4'd1, 4'd5);
    vectors++;
    if (now_t() !== 24'h081500) begin
      $display("FAIL coincident_time: got %h want 081500", now_t()); miscompares++;
    end
    vectors++;
    if (pulses() !== 4'b0000) begin
      $display("FAIL coincident_pulses: got %b want 0000", pulses()); miscompares++;
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (tick_1hz !== (k == 4)) begin
        $display("FAIL coincident_next_tick k=%0d: got %b want %b", k, tick_1hz, (k == 4));
        miscompares++;
      end
    end
    vectors++;
    if (now_t() !== 24'h081501) begin
      $display("FAIL coincident_after: got %h want 081501", now_t()); miscompares++;
    end
  endtask

  task automatic test_set_mode();
    do_load(4'd1, 4'd0, 4'd0, 4'd0);
    repeat (30) step();
    // 7 ticks done, prescaler now at 2.
    set_mode = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      vectors++;
      if (tick_1hz !== 1'b0 || now_t() !== 24'h100007) begin
        $display("FAIL frozen k=%0d: got %h tick=%b want 100007 tick=0", k, now_t(), tick_1hz);
        miscompares++;
      end
    end
    set_mode = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (tick_1hz !== (k == 4)) begin
        $display("FAIL resume_tick k=%0d: got %b want %b", k, tick_1hz, (k == 4));
        miscompares++;
      end
    end
    vectors++;
    if (now_t() !== 24'h100008) begin
      $display("FAIL resume_time: got %h want 100008", now_t()); miscompares++;
    end
  endtask

  task automatic test_async_reset();
    do_load(4'd0, 4'd5, 4'd4, 4'd2);
    repeat (126) step();
    vectors++;
    if (now_t() !== 24'h054231) begin
      $display("FAIL reset_setup: got %h want 054231", now_t()); miscompares++;
    end
    // Reset between clock edges with a pending load.
    set_h1 = 4'd1; set_h0 = 4'd1; set_m1 = 4'd1; set_m0 = 4'd1;
    set_load = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (now_t() !== 24'h000000 || pulses() !== 4'b0000) begin
      $display("FAIL async_reset: got %h pulses=%b want 000000 pulses=0000", now_t(), pulses());
      miscompares++;
    end
    @(negedge clk);
    set_load = 1'b0;
    @(negedge clk);
    vectors++;
    if (now_t() !== 24'h000000) begin
      $display("FAIL reset_load_lost: got %h want 000000", now_t()); miscompares++;
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (tick_1hz !== (k == 4)) begin
        $display("FAIL post_reset_tick k=%0d: got %b want %b", k, tick_1hz, (k == 4));
        miscompares++;
      end
    end
    vectors++;
    if (now_t() !== 24'h000001) begin
      $display("FAIL post_reset_time: got %h want 000001", now_t()); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_rollover(4'd2, 4'd3, 4'd5, 4'd9, 24'h235959, 24'h000000, 1'b1);
    test_rollover(4'd0, 4'd9, 4'd5, 4'd9, 24'h095959, 24'h100000, 1'b0);
    test_bad_load();
    test_load_boundary();
    test_coincident();
    test_set_mode();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
